adc_seq_multibank: RTL and testbench

// - Parametrised triggered ADC sequencer; the successor of the fixed 8-slot sequencer.
// - On trigger, issues a programmable list of channel numbers on an Avalon-ST command stream.
// - Captures the ADC responses into a double-buffered sample store and raises an IRQ.
// - Adds continuous mode, overrun detection and a completed-sequence counter.
// - Sits between the Nios Avalon-MM bus, the timer/PWM trigger source and the Altera modular ADC core.

---
 rtl/adc_seq_multibank.sv | 233 +++++++++++++++++++++++
 tb/tb_adc_seq_multibank.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_seq_multibank.sv
// adc_seq_multibank: triggered ADC channel sequencer with a double-buffered sample store.
//   On trigger it streams map[0..MAXSEQ] as commands, captures the ADC responses into the
//   shadow bank, then swaps banks, raises IRQ_FLAG and bumps SEQCNT on the response eop.
// Optional feature: define ADC_SEQ_OVERSAMPLE_EN to repeat each sequence 2^OSR passes and
//   store the per-slot average; undefined builds one pass and OSR reads 0.
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   chout_valid/ready/data/sop/eop   Avalon-ST command stream to the ADC
//   resp_valid/data/channel/sop/eop  Avalon-ST response stream from the ADC
//   trig_in                          conversion trigger
//   MMS_read/write/address/writedata/readdata  Avalon-MM slave, 0 wait states, comb read
//   irq_out                          IRQ_FLAG & IRQ_EN
module adc_seq_multibank #(
    parameter int unsigned SEQ_DEPTH = 16,
    parameter int unsigned CH_W      = 5,
    parameter int unsigned DATA_W    = 12,
    parameter int unsigned ADDR_W    = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic              chout_valid,
    input  logic              chout_ready,
    output logic [CH_W-1:0]   chout_data,
    output logic              chout_sop,
    output logic              chout_eop,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_data,
    input  logic [CH_W-1:0]   resp_channel,
    input  logic              resp_sop,
    input  logic              resp_eop,
    input  logic              trig_in,
    input  logic              MMS_read,
    input  logic              MMS_write,
    input  logic [ADDR_W-1:0] MMS_address,
    input  logic [31:0]       MMS_writedata,
    output logic [31:0]       MMS_readdata,
    output logic              irq_out
);

    localparam int unsigned IDX_W = $clog2(SEQ_DEPTH);
    localparam int unsigned RGN_W = ADDR_W - IDX_W;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t            state, state_nxt;
    logic              ctrl_en, ctrl_cont, ctrl_irq_en;
    logic              irq_flag, overrun;
    logic [IDX_W-1:0]  maxseq;
    logic [15:0]       seqcnt;
    logic [IDX_W-1:0]  cmd_ctr, resp_ctr;
    logic              bank_sel;

    logic [CH_W-1:0]   map_mem   [SEQ_DEPTH];
    logic [DATA_W-1:0] store_mem [2][SEQ_DEPTH];

    logic [RGN_W-1:0]  region;
    logic [IDX_W-1:0]  aidx;
    logic              wr_ctrl, wr_status, wr_maxseq, wr_seqcnt, wr_osr, wr_map;
    logic              cmd_fire, cmd_last, resp_end;
    logic [IDX_W-1:0]  resp_idx;
    logic              resp_keep;
    logic              last_pass, seq_done, pass_done, overrun_set;
    logic [DATA_W-1:0] sample_val;
    logic [1:0]        osr_rd;
    logic              vis_bank;
    logic              unused_ok;

    // Address decode: upper bits select control / channel map / sample store region
    assign region    = MMS_address[ADDR_W-1:IDX_W];
    assign aidx      = MMS_address[IDX_W-1:0];
    assign wr_ctrl   = MMS_write && (region == RGN_W'(0)) && (aidx == IDX_W'(0));
    assign wr_status = MMS_write && (region == RGN_W'(0)) && (aidx == IDX_W'(1));
    assign wr_maxseq = MMS_write && (region == RGN_W'(0)) && (aidx == IDX_W'(2));
    assign wr_seqcnt = MMS_write && (region == RGN_W'(0)) && (aidx == IDX_W'(3));
    assign wr_osr    = MMS_write && (region == RGN_W'(0)) && (aidx == IDX_W'(4));
    assign wr_map    = MMS_write && (region == RGN_W'(1));

    // Command stream; valid is gated by EN so clearing EN stops commands immediately
    assign chout_valid = (state == ISSUE) && ctrl_en;
    assign chout_data  = map_mem[cmd_ctr];
    assign chout_sop   = (cmd_ctr == IDX_W'(0));
    assign chout_eop   = cmd_last;
    assign cmd_fire    = chout_valid && chout_ready;
    assign cmd_last    = (cmd_ctr == maxseq);

    // Response indexing: sop realigns to slot 0, slots beyond MAXSEQ are dropped
    assign resp_end  = resp_valid && resp_eop;
    assign resp_idx  = resp_sop ? IDX_W'(0) : resp_ctr;
    assign resp_keep = resp_valid && ctrl_en && (resp_idx <= maxseq);

    // Trigger outside IDLE is an overrun, except the expected re-trigger while CONT waits
    assign overrun_set = trig_in && (state != IDLE) && !((state == WAIT) && ctrl_cont);

    assign irq_out  = irq_flag && ctrl_irq_en;
    assign vis_bank = ~bank_sel;

`ifdef ADC_SEQ_OVERSAMPLE_EN
    localparam int unsigned ACC_W = DATA_W + 3;

    logic [1:0]       osr;
    logic [2:0]       pass_ctr;
    logic [ACC_W-1:0] acc_mem [SEQ_DEPTH];
    logic [ACC_W-1:0] acc_sum;

    assign acc_sum    = (pass_ctr == 3'd0) ? ACC_W'(resp_data)
                                           : acc_mem[resp_idx] + ACC_W'(resp_data);
    assign last_pass  = (pass_ctr == 3'((4'd1 << osr) - 4'd1));
    assign sample_val = DATA_W'(acc_sum >> osr);
    assign osr_rd     = osr;

    // Oversampling ratio and pass counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            osr      <= 2'd0;
            pass_ctr <= 3'd0;
        end else begin
            if (wr_osr) osr <= MMS_writedata[1:0];
            if (!ctrl_en || seq_done) pass_ctr <= 3'd0;
            else if (pass_done)       pass_ctr <= pass_ctr + 3'd1;
        end
    end

    // Per-slot accumulators: pass 0 loads, later passes add
    always_ff @(posedge clk) begin
        if (resp_keep) acc_mem[resp_idx] <= acc_sum;
    end
`else
    assign last_pass  = 1'b1;
    assign sample_val = resp_data;
    assign osr_rd     = 2'd0;
`endif

    // Next-state logic; EN low forces IDLE from any state
    always_comb begin
        state_nxt = state;
        seq_done  = 1'b0;
        pass_done = 1'b0;
        if (!ctrl_en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:  if (trig_in) state_nxt = ISSUE;
                ISSUE: if (cmd_fire && cmd_last) state_nxt = WAIT;
                WAIT: begin
                    if (resp_end) begin
                        if (!last_pass) begin
                            pass_done = 1'b1;
                            state_nxt = ISSUE;
                        end else begin
                            seq_done  = 1'b1;
                            state_nxt = ctrl_cont ? ISSUE : IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register, counters, bank select
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            cmd_ctr  <= IDX_W'(0);
            resp_ctr <= IDX_W'(0);
            bank_sel <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!ctrl_en) begin
                cmd_ctr  <= IDX_W'(0);
                resp_ctr <= IDX_W'(0);
            end else begin
                if (cmd_fire) cmd_ctr <= cmd_last ? IDX_W'(0) : cmd_ctr + IDX_W'(1);
                if (resp_valid)
                    resp_ctr <= (resp_idx == IDX_W'(SEQ_DEPTH - 1)) ? resp_idx
                                                                     : resp_idx + IDX_W'(1);
            end
            if (seq_done) bank_sel <= ~bank_sel;
        end
    end

    // Control/status registers; hardware set beats a same-cycle W1C
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_en     <= 1'b0;
            ctrl_cont   <= 1'b0;
            ctrl_irq_en <= 1'b0;
            irq_flag    <= 1'b0;
            overrun     <= 1'b0;
            maxseq      <= IDX_W'(0);
            seqcnt      <= 16'd0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en     <= MMS_writedata[0];
                ctrl_cont   <= MMS_writedata[1];
                ctrl_irq_en <= MMS_writedata[2];
            end
            irq_flag <= seq_done || (irq_flag && !(wr_status && MMS_writedata[0]));
            overrun  <= overrun_set || (overrun && !(wr_status && MMS_writedata[1]));
            if (wr_maxseq) maxseq <= MMS_writedata[IDX_W-1:0];
            if (wr_seqcnt)     seqcnt <= 16'd0;
            else if (seq_done) seqcnt <= seqcnt + 16'd1;
        end
    end

    // Channel map and sample banks; shadow bank = bank_sel, visible bank = ~bank_sel
    always_ff @(posedge clk) begin
        if (wr_map)    map_mem[aidx] <= MMS_writedata[CH_W-1:0];
        if (resp_keep) store_mem[bank_sel][resp_idx] <= sample_val;
    end

    // Combinational read mux
    always_comb begin
        MMS_readdata = 32'd0;
        if (region == RGN_W'(1)) begin
            MMS_readdata = 32'(map_mem[aidx]);
        end else if (region == RGN_W'(2)) begin
            MMS_readdata = 32'(store_mem[vis_bank][aidx]);
        end else if (region == RGN_W'(0)) begin
            case (aidx)
                IDX_W'(0): MMS_readdata = {29'd0, ctrl_irq_en, ctrl_cont, ctrl_en};
                IDX_W'(1): MMS_readdata = {29'd0, (state != IDLE), overrun, irq_flag};
                IDX_W'(2): MMS_readdata = 32'(maxseq);
                IDX_W'(3): MMS_readdata = {16'd0, seqcnt};
                IDX_W'(4): MMS_readdata = {30'd0, osr_rd};
                default:   MMS_readdata = 32'd0;
            endcase
        end
    end

    assign unused_ok = ^{resp_channel, MMS_read, MMS_writedata};

endmodule

// File: tb/tb_adc_seq_multibank.sv
// tb_adc_seq_multibank: directed + randomized bench for adc_seq_multibank (default build).
//   Expected commands come from the programmed map, expected store contents from the
//   responses sent for the last completed sequence.
module tb_adc_seq_multibank;

    localparam int unsigned SEQ_DEPTH = 16;
    localparam int unsigned CH_W      = 5;
    localparam int unsigned DATA_W    = 12;
    localparam int unsigned ADDR_W    = 6;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              chout_valid, chout_ready, chout_sop, chout_eop;
    logic [CH_W-1:0]   chout_data;
    logic              resp_valid, resp_sop, resp_eop;
    logic [DATA_W-1:0] resp_data;
    logic [CH_W-1:0]   resp_channel;
    logic              trig_in;
    logic              MMS_read, MMS_write;
    logic [ADDR_W-1:0] MMS_address;
    logic [31:0]       MMS_writedata, MMS_readdata;
    logic              irq_out;

    int checks = 0;
    int errors = 0;

    int map_m     [SEQ_DEPTH];
    int next_data [SEQ_DEPTH];
    int exp_store [SEQ_DEPTH];
    int cur_max;
    bit prev_valid;
    int prev_max;
    int exp_seqcnt;

    adc_seq_multibank dut (
        .clk(clk), .reset_n(reset_n),
        .chout_valid(chout_valid), .chout_ready(chout_ready), .chout_data(chout_data),
        .chout_sop(chout_sop), .chout_eop(chout_eop),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_channel(resp_channel),
        .resp_sop(resp_sop), .resp_eop(resp_eop),
        .trig_in(trig_in),
        .MMS_read(MMS_read), .MMS_write(MMS_write), .MMS_address(MMS_address),
        .MMS_writedata(MMS_writedata), .MMS_readdata(MMS_readdata),
        .irq_out(irq_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mm_write(input int addr, input logic [31:0] data);
        MMS_address   = ADDR_W'(addr);
        MMS_writedata = data;
        MMS_write     = 1'b1;
        tick();
        MMS_write     = 1'b0;
    endtask

    task automatic mm_read(input int addr, output logic [31:0] data);
        MMS_address = ADDR_W'(addr);
        MMS_read    = 1'b1;
        @(negedge clk);
        data        = MMS_readdata;
        MMS_read    = 1'b0;
    endtask

    // One full sequence: optional trigger, command phase under backpressure mode bp
    // (0 ready=1, 1 toggling, 2 random), then responses from next_data[].
    task automatic do_sequence(input int bp, input bit send_trig, input bit trig_mid,
                               input bit trig_wait, input bit stop_cont);
        int k = 0;
        int cycles = 0;
        bit mid_done = 1'b0;
        logic [31:0] d;
        if (send_trig) begin
            trig_in = 1'b1;
            tick();
            trig_in = 1'b0;
        end
        while (k <= cur_max && cycles < 200) begin
            if (bp == 0)      chout_ready = 1'b1;
            else if (bp == 1) chout_ready = (cycles % 2 == 0);
            else              chout_ready = 1'($urandom_range(1, 0));
            if (chout_valid && chout_ready) begin
                chk("cmd_data", 32'(chout_data), 32'(map_m[k]));
                chk("cmd_sop", 32'(chout_sop), 32'(k == 0));
                chk("cmd_eop", 32'(chout_eop), 32'(k == cur_max));
                if (trig_mid && k == 1 && !mid_done) begin
                    trig_in  = 1'b1;
                    mid_done = 1'b1;
                end
                k++;
            end
            tick();
            trig_in = 1'b0;
            cycles++;
        end
        chout_ready = 1'b0;
        if (k <= cur_max) chk("issue_timeout", 32'(k), 32'(cur_max + 1));
        if (bp == 0) chk("issue_cycles", 32'(cycles), 32'(cur_max + 1));
        for (int i = 0; i <= cur_max; i++) begin
            if (stop_cont && i == cur_max) mm_write(0, 32'h5);
            resp_valid   = 1'b1;
            resp_data    = DATA_W'(next_data[i]);
            resp_channel = CH_W'(map_m[i]);
            resp_sop     = (i == 0);
            resp_eop     = (i == cur_max);
            if (trig_wait && i == 0) trig_in = 1'b1;
            if (prev_valid && i == cur_max) begin
                int j;
                j = $urandom_range(prev_max, 0);
                mm_read(2 * SEQ_DEPTH + j, d);
                chk("mid_read", d, 32'(exp_store[j]));
            end
            tick();
            resp_valid = 1'b0;
            resp_sop   = 1'b0;
            resp_eop   = 1'b0;
            trig_in    = 1'b0;
            repeat ($urandom_range(2, 0)) tick();
        end
        for (int i = 0; i <= cur_max; i++) exp_store[i] = next_data[i];
        prev_valid = 1'b1;
        prev_max   = cur_max;
        exp_seqcnt = (exp_seqcnt + 1) & 16'hFFFF;
        for (int i = 0; i <= cur_max; i++) begin
            mm_read(2 * SEQ_DEPTH + i, d);
            chk("store", d, 32'(exp_store[i]));
        end
        chk("irq_out", 32'(irq_out), 32'd1);
        mm_read(3, d);
        chk("seqcnt", d, 32'(exp_seqcnt));
    endtask

    task automatic set_maxseq(input int m);
        cur_max = m;
        mm_write(2, 32'(m));
    endtask

    task automatic write_map(input int n);
        for (int i = 0; i < n; i++) mm_write(SEQ_DEPTH + i, 32'(map_m[i]));
    endtask

    initial begin
        logic [31:0] d;
        reset_n = 1'b0;
        chout_ready = 1'b0; resp_valid = 1'b0; resp_sop = 1'b0; resp_eop = 1'b0;
        resp_data = '0; resp_channel = '0; trig_in = 1'b0;
        MMS_read = 1'b0; MMS_write = 1'b0; MMS_address = '0; MMS_writedata = '0;
        prev_valid = 1'b0; prev_max = 0; exp_seqcnt = 0; cur_max = 0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();

        // Reset state
        chk("rst_valid", 32'(chout_valid), 32'd0);
        chk("rst_irq", 32'(irq_out), 32'd0);
        for (int a = 0; a < 5; a++) begin
            mm_read(a, d);
            chk("rst_reg", d, 32'd0);
        end

        // Directed: MAXSEQ=3, map {5,2,7,0}, responses 0x111..0x444
        set_maxseq(3);
        map_m[0] = 5; map_m[1] = 2; map_m[2] = 7; map_m[3] = 0;
        write_map(4);
        mm_write(4, 32'h2);
        mm_read(4, d);
        chk("osr_absent", d, 32'd0);
        mm_read(2, d);
        chk("maxseq_rd", d, 32'd3);
        chk("idle_data", 32'(chout_data), 32'd5);
        mm_write(0, 32'h5);
        next_data[0] = 'h111; next_data[1] = 'h222; next_data[2] = 'h333; next_data[3] = 'h444;
        do_sequence(0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Toggling backpressure
        for (int i = 0; i < 4; i++) next_data[i] = $urandom_range(4095, 0);
        do_sequence(1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Trigger during ISSUE -> overrun, then W1C
        for (int i = 0; i < 4; i++) next_data[i] = $urandom_range(4095, 0);
        do_sequence(0, 1'b1, 1'b1, 1'b0, 1'b0);
        mm_read(1, d);
        chk("overrun_set", d, 32'h3);
        mm_write(1, 32'h2);
        mm_read(1, d);
        chk("overrun_w1c", d, 32'h1);
        mm_write(1, 32'h1);
        chk("irq_w1c", 32'(irq_out), 32'd0);

        // Continuous mode, three sequences; trigger in WAIT is ignored
        mm_write(3, 32'hABCD);
        mm_read(3, d);
        chk("seqcnt_clr", d, 32'd0);
        exp_seqcnt = 0;
        mm_write(0, 32'h7);
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 4; i++) next_data[i] = $urandom_range(4095, 0);
            do_sequence(2, (s == 0), 1'b0, 1'b1, (s == 2));
        end
        mm_read(1, d);
        chk("cont_status", d, 32'h1);

        // EN cleared on command slot 2, then restart at slot 0
        chout_ready = 1'b1;
        trig_in = 1'b1;
        tick();
        trig_in = 1'b0;
        tick();
        tick();
        chk("abort_slot2", 32'(chout_data), 32'(map_m[2]));
        mm_write(0, 32'h4);
        chk("abort_gate", 32'(chout_valid), 32'd0);
        chout_ready = 1'b0;
        tick();
        tick();
        mm_read(1, d);
        chk("abort_idle", d, 32'h1);
        mm_read(2 * SEQ_DEPTH + 1, d);
        chk("abort_store", d, 32'(exp_store[1]));
        mm_read(3, d);
        chk("abort_seqcnt", d, 32'(exp_seqcnt));
        mm_write(0, 32'h5);
        for (int i = 0; i < 4; i++) next_data[i] = $urandom_range(4095, 0);
        do_sequence(0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Randomized sequences including MAXSEQ=0 and MAXSEQ=SEQ_DEPTH-1
        for (int r = 0; r < 6; r++) begin
            int m;
            if (r == 0)      m = 0;
            else if (r == 1) m = SEQ_DEPTH - 1;
            else             m = $urandom_range(SEQ_DEPTH - 1, 0);
            set_maxseq(m);
            for (int i = 0; i <= m; i++) begin
                map_m[i]     = $urandom_range(31, 0);
                next_data[i] = $urandom_range(4095, 0);
            end
            write_map(m + 1);
            do_sequence(2, 1'b1, 1'b0, 1'b0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
